// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_pkg
// Description : Shared widths, opcode/funct encodings, ALU op bit positions
//               and divider state encoding for the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

   localparam int ID_TO_EX_WD  = 159;
   localparam int EX_TO_MEM_WD = 82;
   localparam int EX_TO_RF_WD  = 39;
   localparam int DIV_STEPS    = 32;

   // Value of a stall vector bit that freezes the corresponding register
   localparam logic STOP = 1'b1;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   // Bit positions inside the one-hot alu_op field
   localparam int ALU_ADD  = 11;
   localparam int ALU_SUB  = 10;
   localparam int ALU_SLT  = 9;
   localparam int ALU_SLTU = 8;
   localparam int ALU_AND  = 7;
   localparam int ALU_NOR  = 6;
   localparam int ALU_OR   = 5;
   localparam int ALU_XOR  = 4;
   localparam int ALU_SLL  = 3;
   localparam int ALU_SRL  = 2;
   localparam int ALU_SRA  = 1;
   localparam int ALU_LUI  = 0;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_if
// Description : Bundle of the execute stage's pipeline buses, data-SRAM
//               request and stall request. The slave side is the EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_stage_if;
   import ex_stage_pkg::*;

   logic [5:0]              stall;
   logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
   logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
   logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus;
   logic                    data_sram_en;
   logic [3:0]              data_sram_wen;
   logic [31:0]             data_sram_addr;
   logic [31:0]             data_sram_wdata;
   logic                    stallreq_for_ex;

   modport master (
      output stall, id_to_ex_bus,
      input  ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_wen,
             data_sram_addr, data_sram_wdata, stallreq_for_ex
   );

   modport slave (
      input  stall, id_to_ex_bus,
      output ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_wen,
             data_sram_addr, data_sram_wdata, stallreq_for_ex
   );

endinterface
`default_nettype wire

// File: rtl/ex_stage_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_div_iter
// Description : Iterative restoring divider, one quotient bit per cycle.
//               Operands are converted to magnitudes on start and the signs
//               are restored on the outputs. A zero divisor naturally yields
//               an all-ones magnitude quotient and remainder = dividend.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage_div_iter
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic        i_signed,
   input  logic        i_ack,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_quotient,
   output logic [31:0] o_remainder
);

   localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

   div_state_e  r_state;
   div_state_e  w_state_nxt;
   logic [4:0]  r_cnt;
   logic [31:0] r_quo;
   logic [31:0] r_rem;
   logic [31:0] r_dvs;
   logic        r_neg_q;
   logic        r_neg_r;

   logic [31:0] w_abs_dvd;
   logic [31:0] w_abs_dvs;
   logic [32:0] w_trial;
   logic [31:0] w_diff;
   logic        w_ge;

   assign w_abs_dvd = (i_signed && i_dividend[31]) ? (~i_dividend + 32'd1) : i_dividend;
   assign w_abs_dvs = (i_signed && i_divisor[31])  ? (~i_divisor + 32'd1)  : i_divisor;

   // Partial remainder shifted left with the next dividend bit appended
   assign w_trial = {r_rem, r_quo[31]};
   assign w_ge    = (w_trial >= {1'b0, r_dvs});
   assign w_diff  = w_trial[31:0] - r_dvs;

   assign o_quotient  = r_neg_q ? (~r_quo + 32'd1) : r_quo;
   assign o_remainder = r_neg_r ? (~r_rem + 32'd1) : r_rem;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= DIV_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and status; the start cycle already counts as busy
   always_comb begin
      w_state_nxt = r_state;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         DIV_IDLE: begin
            o_busy = i_start;
            if (i_start) w_state_nxt = DIV_BUSY;
         end
         DIV_BUSY: begin
            o_busy = 1'b1;
            if (r_cnt == LAST_STEP) w_state_nxt = DIV_DONE;
         end
         DIV_DONE: begin
            o_done = 1'b1;
            if (i_ack) w_state_nxt = DIV_IDLE;
         end
         default: w_state_nxt = DIV_IDLE;
      endcase
   end

   // Operand capture on start, then one restoring step per busy cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_dvs   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (r_state == DIV_IDLE && i_start) begin
         r_cnt   <= '0;
         r_quo   <= w_abs_dvd;
         r_rem   <= '0;
         r_dvs   <= w_abs_dvs;
         r_neg_q <= i_signed & (i_dividend[31] ^ i_divisor[31]);
         r_neg_r <= i_signed & i_dividend[31];
      end else if (r_state == DIV_BUSY) begin
         r_cnt <= r_cnt + 5'd1;
         r_quo <= {r_quo[30:0], w_ge};
         r_rem <= w_ge ? w_diff : w_trial[31:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : MIPS execute stage: ID/EX register, one-hot ALU, data-SRAM
//               request generation, HI/LO registers with single-cycle
//               multiply and an iterative divider that stalls the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   ex_stage_if.slave ex_if
);

   logic [ID_TO_EX_WD-1:0] r_id_ex;
   logic [31:0]            r_hi;
   logic [31:0]            r_lo;

   logic [31:0] w_pc, w_inst, w_rdata1, w_rdata2;
   logic [11:0] w_alu_op;
   logic [2:0]  w_sel_src1;
   logic [3:0]  w_sel_src2;
   logic        w_ram_en;
   logic [3:0]  w_ram_wen;
   logic        w_rf_we;
   logic [4:0]  w_rf_waddr;
   logic        w_sel_res;

   logic [5:0]  w_opcode, w_funct;
   logic        w_special;
   logic        w_is_mult, w_is_multu, w_is_mthi, w_is_mtlo, w_is_mfhi, w_is_mflo;
   logic        w_is_div, w_div_signed;
   logic [31:0] w_src1, w_src2, w_sra, w_alu_res, w_ex_result;
   logic [4:0]  w_sa;
   logic [63:0] w_prod_s, w_prod_u;
   logic [3:0]  w_byte_wen;
   logic [31:0] w_wdata;
   logic        w_ram_read;
   logic        w_leave;
   logic        w_div_busy, w_div_done;
   logic [31:0] w_quo, w_rem;
   logic        w_unused;

   // ID/EX register: reset, bubble, load or hold
   always_ff @(posedge clk) begin
      if (rst) begin
         r_id_ex <= '0;
      end else if (ex_if.stall[2] == STOP && ex_if.stall[3] != STOP) begin
         r_id_ex <= '0;
      end else if (ex_if.stall[2] != STOP) begin
         r_id_ex <= ex_if.id_to_ex_bus;
      end
   end

   assign {w_pc, w_inst, w_alu_op, w_sel_src1, w_sel_src2, w_ram_en, w_ram_wen,
           w_rf_we, w_rf_waddr, w_sel_res, w_rdata1, w_rdata2} = r_id_ex;

   assign w_opcode     = w_inst[31:26];
   assign w_funct      = w_inst[5:0];
   assign w_special    = (w_opcode == OP_SPECIAL);
   assign w_is_mult    = w_special && (w_funct == FN_MULT);
   assign w_is_multu   = w_special && (w_funct == FN_MULTU);
   assign w_is_mthi    = w_special && (w_funct == FN_MTHI);
   assign w_is_mtlo    = w_special && (w_funct == FN_MTLO);
   assign w_is_mfhi    = w_special && (w_funct == FN_MFHI);
   assign w_is_mflo    = w_special && (w_funct == FN_MFLO);
   assign w_div_signed = w_special && (w_funct == FN_DIV);
   assign w_is_div     = w_div_signed || (w_special && (w_funct == FN_DIVU));
   assign w_leave      = (ex_if.stall[3] != STOP);

   assign w_src1 = ({32{w_sel_src1[0]}} & w_rdata1)
                 | ({32{w_sel_src1[1]}} & w_pc)
                 | ({32{w_sel_src1[2]}} & {27'b0, w_inst[10:6]});
   assign w_src2 = ({32{w_sel_src2[0]}} & w_rdata2)
                 | ({32{w_sel_src2[1]}} & {{16{w_inst[15]}}, w_inst[15:0]})
                 | ({32{w_sel_src2[2]}} & 32'd8)
                 | ({32{w_sel_src2[3]}} & {16'b0, w_inst[15:0]});
   assign w_sa   = w_src1[4:0];
   assign w_sra  = $signed(w_src2) >>> w_sa;

   // One-hot ALU: each selected operation contributes its result
   always_comb begin
      w_alu_res = '0;
      if (w_alu_op[ALU_ADD])  w_alu_res = w_alu_res | (w_src1 + w_src2);
      if (w_alu_op[ALU_SUB])  w_alu_res = w_alu_res | (w_src1 - w_src2);
      if (w_alu_op[ALU_SLT])  w_alu_res = w_alu_res | {31'b0, ($signed(w_src1) < $signed(w_src2))};
      if (w_alu_op[ALU_SLTU]) w_alu_res = w_alu_res | {31'b0, (w_src1 < w_src2)};
      if (w_alu_op[ALU_AND])  w_alu_res = w_alu_res | (w_src1 & w_src2);
      if (w_alu_op[ALU_NOR])  w_alu_res = w_alu_res | ~(w_src1 | w_src2);
      if (w_alu_op[ALU_OR])   w_alu_res = w_alu_res | (w_src1 | w_src2);
      if (w_alu_op[ALU_XOR])  w_alu_res = w_alu_res | (w_src1 ^ w_src2);
      if (w_alu_op[ALU_SLL])  w_alu_res = w_alu_res | (w_src2 << w_sa);
      if (w_alu_op[ALU_SRL])  w_alu_res = w_alu_res | (w_src2 >> w_sa);
      if (w_alu_op[ALU_SRA])  w_alu_res = w_alu_res | w_sra;
      if (w_alu_op[ALU_LUI])  w_alu_res = w_alu_res | {w_src2[15:0], 16'b0};
   end

   // Result select: HI/LO reads bypass the ALU
   always_comb begin
      w_ex_result = w_alu_res;
      if (w_is_mfhi)      w_ex_result = r_hi;
      else if (w_is_mflo) w_ex_result = r_lo;
   end

   // Store lane enables and replicated data; a load keeps all lanes off
   always_comb begin
      w_byte_wen = 4'b0000;
      w_wdata    = w_rdata2;
      case (w_opcode)
         OP_SB: begin
            w_byte_wen = 4'b0001 << w_alu_res[1:0];
            w_wdata    = {4{w_rdata2[7:0]}};
         end
         OP_SH: begin
            w_byte_wen = 4'b0011 << {w_alu_res[1], 1'b0};
            w_wdata    = {2{w_rdata2[15:0]}};
         end
         OP_SW:   w_byte_wen = 4'b1111;
         default: w_byte_wen = 4'b0000;
      endcase
      if (!(w_ram_en && (|w_ram_wen))) w_byte_wen = 4'b0000;
   end

   assign w_ram_read = w_ram_en & ~(|w_byte_wen);

   assign w_prod_s = {{32{w_rdata1[31]}}, w_rdata1} * {{32{w_rdata2[31]}}, w_rdata2};
   assign w_prod_u = {32'b0, w_rdata1} * {32'b0, w_rdata2};

   ex_stage_div_iter u_div (
      .clk         (clk),
      .rst         (rst),
      .i_start     (w_is_div),
      .i_signed    (w_div_signed),
      .i_ack       (w_leave),
      .i_dividend  (w_rdata1),
      .i_divisor   (w_rdata2),
      .o_busy      (w_div_busy),
      .o_done      (w_div_done),
      .o_quotient  (w_quo),
      .o_remainder (w_rem)
   );

   // HI/LO commit as the instruction moves on to MEM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_leave) begin
         if (w_is_mult) begin
            {r_hi, r_lo} <= w_prod_s;
         end else if (w_is_multu) begin
            {r_hi, r_lo} <= w_prod_u;
         end else if (w_is_mthi) begin
            r_hi <= w_rdata1;
         end else if (w_is_mtlo) begin
            r_lo <= w_rdata1;
         end else if (w_is_div && w_div_done) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
         end
      end
   end

   assign ex_if.ex_to_mem_bus   = {w_pc, w_ram_en, w_byte_wen, w_sel_res, w_rf_we,
                                   w_rf_waddr, w_ex_result, w_opcode};
   assign ex_if.ex_to_rf_bus    = {w_ram_read, w_rf_we, w_rf_waddr, w_ex_result};
   assign ex_if.data_sram_en    = w_ram_en;
   assign ex_if.data_sram_wen   = w_byte_wen;
   assign ex_if.data_sram_addr  = w_alu_res;
   assign ex_if.data_sram_wdata = w_wdata;
   assign ex_if.stallreq_for_ex = w_div_busy;

   // Register-field bits and stall lanes this stage does not consume
   assign w_unused = ^{w_inst[25:16], ex_if.stall[5:4], ex_if.stall[1:0]};

endmodule
`default_nettype wire
